// File: rtl/oversample_filter.sv
// ---------------------------------------------------------------------------
// oversample_filter
//
// Decimating boxcar averager that sits between the ADC capture logic and
// pid_core. It sums 2^os consecutive valid samples and emits their mean as a
// single signed sample with a one-cycle valid strobe. os = 0 is pass-through.
// The ratio is staged on the frontpanel update handshake and only takes
// effect on a frame boundary, so a frame is never averaged with a mixed ratio.
//
// Build option: define OS_ROUND_EN to round the mean half toward +inf (with
// saturation to the positive full-scale value); otherwise the mean is the
// floor of the exact average (plain arithmetic shift).
//
// Ports:
//   clk_in          in   1       system clock
//   reset_in        in   1       asynchronous active-low reset
//   data_in         in   W_DATA  signed ADC sample
//   data_valid_in   in   1       sample strobe, back-to-back allowed
//   os_in           in   W_EP    requested log2 oversample ratio (unsigned)
//   update_en_in    in   1       enables update_in
//   update_in       in   1       request to latch os_in
//   clear_in        in   1       synchronous discard of the partial frame
//   data_out        out  W_DATA  signed averaged sample (held between strobes)
//   data_valid_out  out  1       one-cycle strobe marking a new data_out
// ---------------------------------------------------------------------------
module oversample_filter #(
  parameter int W_DATA  = 18,
  parameter int W_EP    = 16,
  parameter int MAX_OS  = 6,
  parameter int OS_INIT = 0
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [W_DATA-1:0] data_in,
  input  logic              data_valid_in,
  input  logic [W_EP-1:0]   os_in,
  input  logic              update_en_in,
  input  logic              update_in,
  input  logic              clear_in,
  output logic [W_DATA-1:0] data_out,
  output logic              data_valid_out
);

  localparam int W_ACC = W_DATA + MAX_OS;
  localparam int W_OS  = $clog2(MAX_OS + 1);

  // Clamp the frontpanel request into the supported range.
  function automatic logic [W_OS-1:0] clamp_os(input logic [W_EP-1:0] req);
    if (req > W_EP'(MAX_OS)) return W_OS'(MAX_OS);
    else                     return req[W_OS-1:0];
  endfunction

  // Divide the frame sum by 2^sh. The sum of 2^sh in-range samples divided
  // by 2^sh is always in range, so truncation to W_DATA bits is lossless.
  function automatic logic signed [W_DATA-1:0] frame_mean(
    input logic signed [W_ACC-1:0] sum,
    input logic        [W_OS-1:0]  sh
  );
    logic signed [W_ACC-1:0] t;
`ifdef OS_ROUND_EN
    logic signed [W_ACC-1:0] pos_max;
    pos_max = $signed((W_ACC'(1) << (W_DATA - 1)) - W_ACC'(1));
    t = sum;
    if (sh != '0) t = sum + $signed(W_ACC'(1) << (sh - W_OS'(1)));
    t = t >>> sh;
    if (t > pos_max) t = pos_max;
`else
    t = sum >>> sh;
`endif
    return t[W_DATA-1:0];
  endfunction

  logic        [W_OS-1:0]   os_q, os_d;
  logic        [W_OS-1:0]   os_pend_q, os_pend_d;
  logic                     pend_q, pend_d;
  logic signed [W_ACC-1:0]  acc_q, acc_d;
  logic        [MAX_OS-1:0] cnt_q, cnt_d;
  logic signed [W_DATA-1:0] dout_q, dout_d;
  logic                     vld_q, vld_d;

  logic        [MAX_OS-1:0] last_idx;
  logic signed [W_ACC-1:0]  sample_ext;
  logic signed [W_ACC-1:0]  sum;
  logic                     frame_end;
  logic                     boundary;

  // last_idx = 2^os - 1, i.e. a mask of os low ones.
  always_comb begin
    last_idx = '0;
    for (int i = 0; i < MAX_OS; i++) begin
      if (i < int'(os_q)) last_idx[i] = 1'b1;
    end
  end

  assign sample_ext = {{MAX_OS{data_in[W_DATA-1]}}, data_in};
  assign sum        = acc_q + sample_ext;
  assign frame_end  = data_valid_in & ~clear_in & (cnt_q == last_idx);
  // A staged ratio may be applied on clear, on an idle cycle with no frame
  // in progress, or on the edge that closes the current frame.
  assign boundary   = clear_in | ((cnt_q == '0) & ~data_valid_in) | frame_end;

  always_comb begin
    os_d      = os_q;
    os_pend_d = os_pend_q;
    pend_d    = pend_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    vld_d     = 1'b0;

    if (clear_in) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (data_valid_in) begin
      if (frame_end) begin
        dout_d = frame_mean(sum, os_q);
        vld_d  = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + MAX_OS'(1);
      end
    end

    if (boundary && pend_q) begin
      os_d   = os_pend_q;
      pend_d = 1'b0;
    end

    // A fresh request (re)stages the value even if an older one is applied
    // on this same edge.
    if (update_in && update_en_in) begin
      os_pend_d = clamp_os(os_in);
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      os_q      <= W_OS'(OS_INIT);
      os_pend_q <= '0;
      pend_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
    end else begin
      os_q      <= os_d;
      os_pend_q <= os_pend_d;
      pend_q    <= pend_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
    end
  end

  assign data_out       = dout_q;
  assign data_valid_out = vld_q;

endmodule

// File: doc/oversample_filter.md
# oversample_filter

Decimating boxcar averager between the ADC capture logic and `pid_core`. It accumulates 2^os consecutive valid input samples and emits their mean as one signed sample with a one-cycle valid strobe. Its output drives `pid_core` `data_in` / `data_valid_in`. The oversample ratio is a frontpanel parameter, latched on the same update handshake as the PID coefficients.

## Interface
Parameters:
- `W_DATA`, 18: sample width in and out, signed.
- `W_EP`, 16: frontpanel endpoint width.
- `MAX_OS`, 6: maximum log2 oversample ratio. Accumulator width is `W_DATA+MAX_OS`.
- `OS_INIT`, 0: oversample mode after reset.

Ports:
- `clk_in`, input, 1: system clock.
- `reset_in`, input, 1: system reset. Asynchronous, active-low.
- `data_in`, input, W_DATA: signed ADC sample.
- `data_valid_in`, input, 1: sample valid strobe. Any duty cycle, back-to-back allowed.
- `os_in`, input, W_EP: requested log2 oversample ratio, unsigned.
- `update_en_in`, input, 1: sensitizes the block to `update_in`.
- `update_in`, input, 1: pulse that requests latching of `os_in`.
- `clear_in`, input, 1: synchronous discard of the partial frame.
- `data_out`, output, W_DATA: signed averaged sample.
- `data_valid_out`, output, 1: one-cycle strobe marking a new `data_out`.

## Operation
- Registers:
  - `os`: active mode, 0..MAX_OS.
  - `os_pend` plus `pend_flag`: staged update.
  - `acc`: signed, W_DATA+MAX_OS bits.
  - `cnt`: MAX_OS bits, samples taken in the current frame.
  - `data_out` and `data_valid_out`: output registers.
- Frame length is N = 2^os samples.
- Each accepted sample updates `acc <= acc + sext(data_in)` and `cnt <= cnt + 1`.
- On the sample where `cnt == N-1`:
  - `data_out <= (acc + sext(data_in)) >>> os`. This is an arithmetic shift; the result is truncated to W_DATA bits, which is always in range.
  - `data_valid_out <= 1`.
  - `acc <= 0`, `cnt <= 0`.
- `data_valid_out` is 0 on every other cycle. `data_out` holds its last value between strobes.
- `os = 0` is pass-through: every valid sample is reproduced on the next cycle.
- Parameter update:
  - When `update_in & update_en_in` is sampled, `os_pend <= min(os_in, MAX_OS)` and `pend_flag <= 1`.
  - The staged value is copied into `os` only at a frame boundary: when `cnt == 0` with no sample accepted that cycle, or on the frame-closing sample edge.
  - A new update while one is pending overwrites `os_pend`.
  - A frame is therefore never averaged with a mixed ratio.
- `clear_in`:
  - `acc <= 0`, `cnt <= 0`, with priority over a simultaneous `data_valid_in`; that sample is dropped and no strobe is produced.
  - A pending `os` update is applied on the clear cycle.
  - `data_out` and `os` are otherwise unaffected.
- Reset, asynchronous at any time including mid-frame:
  - `acc = 0`, `cnt = 0`, `os = OS_INIT`, `pend_flag = 0`.
  - `data_out = 0`, `data_valid_out = 0`.
  - The partial frame is lost. The first sample after reset deassertion starts a new frame.

## Timing
- Latency: `data_valid_out` is high in the cycle immediately after the clock edge that accepts the frame's last sample, i.e. one cycle. `data_out` is valid in that same cycle.
- Throughput: one input sample per cycle, with no stalls. No input is dropped except under `clear_in` or reset.
- Output strobe spacing is at least N cycles.
- The downstream `pid_core` ignores strobes while busy. Spacing of at least 1+3 cycles requires `os >= 2` or input rate no more than 1/4 of the clock; this is a system-level constraint, not enforced here.
- The update latch takes effect one cycle after the `update_in` edge at the earliest. The ratio applies from the next frame start.

## Configuration
- `OS_ROUND_EN`:
  - Defined: for `os > 0`, 2^(os-1) is added to the sum before the shift (round half toward +inf). Saturate to +max(W_DATA) if the rounded result exceeds it.
  - Undefined: plain arithmetic shift (floor), no rounding adder.
  - `os = 0` is identical in both builds.

## Test plan
- Pass-through: `os=0` (reset default), inputs 5, -3, 131071 on consecutive cycles -> `data_out` is 5, -3, 131071, each one cycle after its input, with a strobe on each.
- Averaging: update to `os=2`, inputs 10, 20, 30, 41 -> a single strobe with `data_out=25`. Then inputs 1, 1, 1, 0 -> `data_out=0` in the floor build, or 1 with `OS_ROUND_EN`.
- Extremes: `os=6`, 64 samples of -131072 -> -131072. Then 64 samples of 131071 -> 131071. No wrap in either case.
- Mid-frame update: `os=2`, two samples taken, then update to `os=0` -> the frame completes after 2 more samples with a 4-sample average. Subsequent samples are passed through.
- Clear and clamp:
  - `os=3`, 5 samples taken, then `clear_in` together with a sample of 999 -> no strobe, and 999 is discarded. The next 8 samples of 7 -> `data_out=7`.
  - `os_in=40` -> `os=6`.
- Reset mid-frame: `os=1`, one sample of 100, then assert `reset_in` low asynchronously -> `data_out=0` and `data_valid_out=0` immediately, `os=OS_INIT`. After release, input 8 -> output 8 on the next cycle (with `OS_INIT=0`).
